// File: rtl/j1_irq_ctrl.sv
// Multi-source interrupt controller for the j1 core: edge latch, per-source mask, priority dispatch.
// Define IRQ_SYNC_EN to pass irq_src through a 2-flop synchronizer for asynchronous pin sources.
module j1_irq_ctrl #(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'h0100
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     io_addr,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cpu_safe,
  output logic            interrupt
);

  localparam logic [1:0] S_DIS   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  logic [NSRC-1:0] src;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] pend_set;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] dispatch_clr;
  logic [3:0]      cause;
  logic [3:0]      winner;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            sel;
  logic            wr_pend;
  logic            wr_en;
  logic            wr_ctrl;
  logic            ctrl_set;
  logic            ctrl_clr;
  logic            unused_bits;

  // Lowest set index wins: source 0 has the highest priority.
  function automatic logic [3:0] first_set(input logic [NSRC-1:0] v);
    first_set = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (v[i]) first_set = 4'(i);
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [3:0] k);
    onehot = '0;
    for (int i = 0; i < NSRC; i++)
      onehot[i] = (4'(i) == k);
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync_p0;
  logic [NSRC-1:0] sync_p1;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_src;
      sync_p1 <= sync_p0;
    end
  end

  assign src = sync_p1;
`else
  assign src = irq_src;
`endif

  assign unused_bits = &{1'b0, io_addr[0], io_wdata};

  assign sel      = (io_addr[15:3] == BASE[15:3]);
  assign wr_pend  = io_wr & sel & (io_addr[2:1] == 2'd0);
  assign wr_en    = io_wr & sel & (io_addr[2:1] == 2'd1);
  assign wr_ctrl  = io_wr & sel & (io_addr[2:1] == 2'd3);
  assign ctrl_set = wr_ctrl & io_wdata[0];
  assign ctrl_clr = wr_ctrl & ~io_wdata[0];

  assign pend_set = src & ~prev;
  assign req      = pending & enable;
  assign winner   = first_set(req);
  assign w1c      = wr_pend ? io_wdata[NSRC-1:0] : '0;

  // A GIE clear written in the same ARMED cycle suppresses the dispatch.
  assign interrupt    = (state == S_ARMED) & (|req) & cpu_safe & ~ctrl_clr;
  assign dispatch_clr = interrupt ? onehot(winner) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_DIS:   if (ctrl_set) state_nxt = S_HOLD;
      S_HOLD:  state_nxt = ctrl_clr ? S_DIS : S_ARMED;
      S_ARMED: if (ctrl_clr || interrupt) state_nxt = S_DIS;
      default: state_nxt = S_DIS;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      prev    <= '0;
      pending <= '0;
      enable  <= '0;
      cause   <= '0;
      state   <= S_DIS;
    end else begin
      prev    <= src;
      pending <= (pending & ~w1c & ~dispatch_clr) | pend_set;
      if (wr_en) enable <= io_wdata[NSRC-1:0];
      if (interrupt) cause <= winner;
      state   <= state_nxt;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_rd && sel) begin
      case (io_addr[2:1])
        2'd0: io_rdata[NSRC-1:0] = pending;
        2'd1: io_rdata[NSRC-1:0] = enable;
        2'd2: io_rdata[3:0]      = cause;
        default: begin
          io_rdata[0] = (state != S_DIS);
          io_rdata[1] = |req;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Directed bench for j1_irq_ctrl: behavioural model compared every cycle plus literal expectations.
module tb_j1_irq_ctrl;

  localparam int          NSRC = 8;
  localparam logic [15:0] BASE = 16'h0100;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            resetq;
  logic            io_rd;
  logic            io_wr;
  logic [15:0]     io_addr;
  logic [15:0]     io_wdata;
  logic [15:0]     io_rdata;
  logic [NSRC-1:0] irq_src;
  logic            cpu_safe;
  logic            interrupt;

  int n_chk  = 0;
  int n_fail = 0;

  j1_irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .irq_src(irq_src), .cpu_safe(cpu_safe), .interrupt(interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what software would see, held as plain bit vectors and counters.
  logic [NSRC-1:0] m_pend, m_en, m_prev, m_h1, m_h2;
  int              m_cause;
  bit              m_gie;
  int              m_age;

  function automatic int lowest(input logic [NSRC-1:0] v);
    lowest = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (v[i]) lowest = i;
  endfunction

  function automatic bit selected();
    return io_addr[15:3] == BASE[15:3];
  endfunction

  function automatic bit exp_irq();
    bit gie_cleared;
    gie_cleared = io_wr && selected() && io_addr[2:1] == 2'd3 && !io_wdata[0];
    return resetq && m_gie && m_age >= 1 && (m_pend & m_en) != 0 && cpu_safe && !gie_cleared;
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (!resetq || !(io_rd && selected())) return 16'h0;
    case (io_addr[2:1])
      2'd0:    return 16'(m_pend);
      2'd1:    return 16'(m_en);
      2'd2:    return 16'(m_cause);
      default: return {14'h0, ((m_pend & m_en) != 0), m_gie};
    endcase
  endfunction

  always @(posedge clk or negedge resetq) begin : model
    logic [NSRC-1:0] seen, setv, w1c, nxt;
    bit fire, clr_w, set_w;
    int k;
    if (!resetq) begin
      m_pend <= '0; m_en <= '0; m_prev <= '0; m_h1 <= '0; m_h2 <= '0;
      m_cause <= 0; m_gie <= 0; m_age <= 0;
    end else begin
      fire = exp_irq();
      k    = lowest(m_pend & m_en);
`ifdef IRQ_SYNC_EN
      seen = m_h2;
`else
      seen = irq_src;
`endif
      setv  = seen & ~m_prev;
      w1c   = (io_wr && selected() && io_addr[2:1] == 2'd0) ? io_wdata[NSRC-1:0] : '0;
      clr_w = io_wr && selected() && io_addr[2:1] == 2'd3 && !io_wdata[0];
      set_w = io_wr && selected() && io_addr[2:1] == 2'd3 && io_wdata[0];
      for (int i = 0; i < NSRC; i++)
        nxt[i] = setv[i] ? 1'b1 : ((w1c[i] || (fire && i == k)) ? 1'b0 : m_pend[i]);
      m_pend <= nxt;
      m_prev <= seen;
      m_h2   <= m_h1;
      m_h1   <= irq_src;
      if (io_wr && selected() && io_addr[2:1] == 2'd1) m_en <= io_wdata[NSRC-1:0];
      if (clr_w) m_gie <= 0;
      else if (fire) begin
        m_gie   <= 0;
        m_cause <= k;
      end else if (set_w && !m_gie) begin
        m_gie <= 1;
        m_age <= 0;
      end else if (m_gie) m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    check("interrupt_model", {15'h0, interrupt}, {15'h0, exp_irq()});
    check("io_rdata_model", io_rdata, exp_rdata());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] d);
    io_wr = 1'b1; io_addr = BASE | {13'h0, idx, 1'b0}; io_wdata = d;
    tick();
    io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [15:0] exp, input string name);
    io_rd = 1'b1; io_addr = BASE | {13'h0, idx, 1'b0};
    #1;
    check(name, io_rdata, exp);
    io_rd = 1'b0; io_addr = 16'h0;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    check(name, {15'h0, interrupt}, {15'h0, exp});
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    irq_src = m;
    tick();
    irq_src = '0;
  endtask

  initial begin
    resetq = 1'b0; io_rd = 0; io_wr = 0; io_addr = 0; io_wdata = 0;
    irq_src = '0; cpu_safe = 1'b1;
    tick(); tick();
    resetq = 1'b1;
    tick();
    chk_irq(1'b0, "reset_irq");
    rd(2'd0, 16'h0, "reset_pending");
    rd(2'd1, 16'h0, "reset_enable");
    rd(2'd3, 16'h0, "reset_ctrl");

    // single source dispatch and HOLD cycle timing
    wr(2'd1, 16'h0005);
    pulse(8'h04);
    repeat (LAT - 1) tick();
    rd(2'd0, 16'h0004, "t1_pending");
    wr(2'd3, 16'h0001);
    chk_irq(1'b0, "t1_hold_no_irq");
    tick();
    chk_irq(1'b1, "t1_armed_irq");
    tick();
    chk_irq(1'b0, "t1_single_pulse");
    rd(2'd2, 16'h0002, "t1_cause");
    rd(2'd0, 16'h0000, "t1_pending_cleared");
    rd(2'd3, 16'h0000, "t1_gie_cleared");

    // priority between simultaneous sources
    wr(2'd1, 16'h00FF);
    pulse(8'h42);
    repeat (LAT - 1) tick();
    wr(2'd3, 16'h0001);
    tick(); tick();
    rd(2'd2, 16'h0001, "t2_cause_first");
    rd(2'd0, 16'h0040, "t2_pending_left");
    rd(2'd3, 16'h0002, "t2_ctrl_req");
    wr(2'd3, 16'h0001);
    tick(); tick();
    rd(2'd2, 16'h0006, "t2_cause_second");
    rd(2'd0, 16'h0000, "t2_pending_empty");

    // cpu_safe gating
    cpu_safe = 1'b0;
    pulse(8'h10);
    repeat (LAT - 1) tick();
    wr(2'd3, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_irq(1'b0, "t3_unsafe");
    end
    cpu_safe = 1'b1;
    #1;
    chk_irq(1'b1, "t3_safe_fire");
    tick();
    chk_irq(1'b0, "t3_after_fire");
    rd(2'd2, 16'h0004, "t3_cause");

    // masked source stays latched, dispatches once unmasked
    wr(2'd1, 16'h0000);
    pulse(8'h08);
    repeat (LAT + 1) tick();
    chk_irq(1'b0, "t4_masked_no_irq");
    rd(2'd0, 16'h0008, "t4_pending_masked");
    wr(2'd3, 16'h0001);
    repeat (3) tick();
    chk_irq(1'b0, "t4_armed_masked");
    rd(2'd3, 16'h0001, "t4_ctrl_gie");
    wr(2'd1, 16'h0008);
    chk_irq(1'b1, "t4_unmask_fire");
    tick();
    rd(2'd2, 16'h0003, "t4_cause");
    rd(2'd0, 16'h0000, "t4_pending_cleared");
    pulse(8'h08);
    repeat (LAT + 1) tick();
    io_wr = 1'b1; io_addr = BASE; io_wdata = 16'h0008; irq_src = 8'h08;
    tick();
    io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0; irq_src = '0;
    repeat (LAT - 1) tick();
    rd(2'd0, 16'h0008, "t4_set_beats_w1c");
    wr(2'd0, 16'h00FF);

    // asynchronous reset while dispatching
    wr(2'd1, 16'h00FF);
    pulse(8'h20);
    repeat (LAT - 1) tick();
    wr(2'd3, 16'h0001);
    tick();
    chk_irq(1'b1, "t5_armed_irq");
    resetq = 1'b0;
    #1;
    chk_irq(1'b0, "t5_reset_irq");
    io_rd = 1'b1; io_addr = BASE;
    #1;
    check("t5_reset_rdata", io_rdata, 16'h0);
    io_rd = 1'b0; io_addr = 16'h0;
    tick();
    resetq = 1'b1;
    tick();
    rd(2'd0, 16'h0, "t5_pending");
    rd(2'd1, 16'h0, "t5_enable");
    rd(2'd2, 16'h0, "t5_cause");
    rd(2'd3, 16'h0, "t5_ctrl");

    // event latency
    irq_src = 8'h01;
    rd(2'd0, 16'h0, "t6_before_edge");
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      rd(2'd0, 16'h0, "t6_in_sync");
    end
    tick();
    rd(2'd0, 16'h0001, "t6_latched");
    irq_src = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
